// File: rtl/pipe_alu_elastic_if.sv
// Handshake and data bundle for the elastic ALU pipeline.
// The producer/consumer side uses master, the pipeline uses slave.
interface pipe_alu_elastic_if #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int LO_W   = 8
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data;
  logic [LO_W-1:0]  lo;
  logic             tag;
  logic             carry;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, a, b, op, flush, out_ready,
    input  in_ready, out_valid, data, lo, tag, carry, occupancy
  );

  modport slave (
    input  in_valid, a, b, op, flush, out_ready,
    output in_ready, out_valid, data, lo, tag, carry, occupancy
  );
endinterface

// File: rtl/pipe_alu_elastic.sv
// Elastic ALU pipeline: the result {carry, tag, data} is computed at the
// input and then carried through STAGES slots, each of which has its own
// valid bit. A slot advances whenever it is empty or when the slot below it
// advances, so bubbles collapse and full throughput holds under backpressure.
module pipe_alu_elastic #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int LO_W   = 8
) (
  input logic              sys_clk,
  input logic              sys_rst,
  pipe_alu_elastic_if.slave bus
);
  localparam int PW    = WIDTH + 2;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid;
  logic [PW-1:0]     payload    [STAGES];
  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] up_valid;
  logic [PW-1:0]     up_payload [STAGES];
  logic [PW-1:0]     in_payload;
  logic [WIDTH:0]    sum_x;
  logic [WIDTH:0]    diff_x;
  logic [WIDTH-1:0]  res;
  logic              cy;
  logic              rdy_acc;
  logic              accept;
  logic [OCC_W-1:0]  occ;

  // Operation select. Add and sub are evaluated one bit wider so that the
  // top bit is the carry-out or the borrow.
  always_comb begin
    sum_x  = {1'b0, bus.a} + {1'b0, bus.b};
    diff_x = {1'b0, bus.a} - {1'b0, bus.b};
    res    = '0;
    cy     = 1'b0;
    case (bus.op)
      2'b00: begin
        res = sum_x[WIDTH-1:0];
        cy  = sum_x[WIDTH];
      end
      2'b01: res = bus.a ^ bus.b;
      2'b10: begin
        res = diff_x[WIDTH-1:0];
        cy  = diff_x[WIDTH];
      end
      default: res = bus.a & bus.b;
    endcase
    in_payload = {cy, (bus.a == bus.b), res};
  end

  // A slot can load if it or any slot further downstream is empty, or if the
  // consumer is taking the result. This is written as an OR-scan so the
  // ready chain has no self-referencing vector.
  always_comb begin
    rdy_acc = bus.out_ready;
    ready   = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      rdy_acc  = rdy_acc | ~valid[i];
      ready[i] = rdy_acc;
    end
  end

  assign bus.in_ready = ready[0] & ~bus.flush;
  assign accept       = bus.in_valid & bus.in_ready;

  assign up_valid[0]   = accept;
  assign up_payload[0] = in_payload;

  for (genvar g = 1; g < STAGES; g++) begin : g_up
    assign up_valid[g]   = valid[g-1];
    assign up_payload[g] = payload[g-1];
  end

  // Slot registers: flush clears only the valid bits. A bubble moving into a
  // slot leaves its payload untouched.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      valid <= '0;
      for (int i = 0; i < STAGES; i++) payload[i] <= '0;
    end else if (bus.flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ready[i]) begin
          valid[i] <= up_valid[i];
          if (up_valid[i]) payload[i] <= up_payload[i];
        end
      end
    end
  end

  // Occupancy is the popcount of the registered valid bits.
  always_comb begin
    occ = '0;
    for (int i = 0; i < STAGES; i++) occ = occ + OCC_W'(valid[i]);
  end

  assign bus.occupancy = occ;
  assign bus.out_valid = valid[STAGES-1];
  assign bus.data      = payload[STAGES-1][WIDTH-1:0];
  assign bus.tag       = payload[STAGES-1][WIDTH];
  assign bus.carry     = payload[STAGES-1][WIDTH+1];
  assign bus.lo        = payload[STAGES-1][LO_W-1:0];
endmodule

// File: tb/tb_pipe_alu_elastic.sv
// Directed bench for pipe_alu_elastic (WIDTH=16, STAGES=3, LO_W=8).
module tb_pipe_alu_elastic;
  localparam int W = 16;
  localparam int S = 3;
  localparam int L = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         tag;
    logic         carry;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] exp_data;
    logic         exp_tag;
    logic         exp_carry;
  } vec_t;

  logic sys_clk;
  logic sys_rst;
  int   n_checks;
  int   n_fail;
  int   n_acc;
  res_t q[$];
  vec_t vec[10];

  pipe_alu_elastic_if #(.WIDTH(W), .STAGES(S), .LO_W(L)) bus ();

  pipe_alu_elastic #(.WIDTH(W), .STAGES(S), .LO_W(L)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus.slave)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    res_t r;
    logic [W:0] t;
    r.tag   = (a == b);
    r.carry = 1'b0;
    r.data  = '0;
    case (op)
      2'd0: begin
        t = {1'b0, a} + {1'b0, b};
        r.data  = t[W-1:0];
        r.carry = t[W];
      end
      2'd1: r.data = a ^ b;
      2'd2: begin
        r.data  = a - b;
        r.carry = (a < b);
      end
      default: r.data = a & b;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
  endtask

  // One clock with scoreboarding: checks the presented result against the
  // oldest expected entry, then tracks accept/deliver/flush and occupancy.
  task automatic step();
    #1;
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_valid_unexpected: got 1, expected 0 at %0t", $time);
      end else begin
        chk("data", 32'(bus.data), 32'(q[0].data));
        chk("lo", 32'(bus.lo), 32'(q[0].data[L-1:0]));
        chk("tag", 32'(bus.tag), 32'(q[0].tag));
        chk("carry", 32'(bus.carry), 32'(q[0].carry));
        if (bus.out_ready && !bus.flush) void'(q.pop_front());
      end
    end
    if (bus.flush) q.delete();
    else if (bus.in_valid && bus.in_ready) begin
      q.push_back(model(bus.a, bus.b, bus.op));
      n_acc++;
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0);
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      step();
    end
    chk(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int idx;
    n_checks = 0;
    n_fail   = 0;
    n_acc    = 0;

    vec[0] = '{16'h1234, 16'h0F0F, 2'd0, 16'h2143, 1'b0, 1'b0};
    vec[1] = '{16'hFFFF, 16'h0001, 2'd0, 16'h0000, 1'b0, 1'b1};
    vec[2] = '{16'h00FF, 16'h0F0F, 2'd1, 16'h0FF0, 1'b0, 1'b0};
    vec[3] = '{16'h0001, 16'h0002, 2'd2, 16'hFFFF, 1'b0, 1'b1};
    vec[4] = '{16'hAAAA, 16'hAAAA, 2'd3, 16'hAAAA, 1'b1, 1'b0};
    vec[5] = '{16'h5555, 16'h5555, 2'd2, 16'h0000, 1'b1, 1'b0};
    vec[6] = '{16'h8000, 16'h8000, 2'd0, 16'h0000, 1'b1, 1'b1};
    vec[7] = '{16'hFFFF, 16'hFFFF, 2'd1, 16'h0000, 1'b1, 1'b0};
    vec[8] = '{16'h0000, 16'h0001, 2'd2, 16'hFFFF, 1'b0, 1'b1};
    vec[9] = '{16'h1234, 16'h0F0F, 2'd3, 16'h0204, 1'b0, 1'b0};

    sys_rst       = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'd0);

    // Reset values
    repeat (2) @(negedge sys_clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_lo", 32'(bus.lo), 32'd0);
    chk("rst_tag", 32'(bus.tag), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    sys_rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Back-to-back table stream with fixed latency
    for (int cyc = 0; cyc < 10 + S; cyc++) begin
      if (cyc < 10) drive(1'b1, vec[cyc].a, vec[cyc].b, vec[cyc].op);
      else drive(1'b0, '0, '0, 2'd0);
      #1;
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      idx = cyc - (S - 1);
      if (idx >= 0 && idx < 10) begin
        chk("stream_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_data", 32'(bus.data), 32'(vec[idx].exp_data));
        chk("stream_tag", 32'(bus.tag), 32'(vec[idx].exp_tag));
        chk("stream_carry", 32'(bus.carry), 32'(vec[idx].exp_carry));
      end else begin
        chk("stream_idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
    end
    drain("stream_drain");

    // Stall: continuous input with out_ready low fills exactly S slots
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, W'(16'h1000 + k), W'(16'h0100 * k), 2'(k));
      step();
    end
    #1;
    chk("stall_accepted", 32'(n_acc), 32'(S));
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_occupancy", 32'(bus.occupancy), 32'(S));
    chk("stall_data_first", 32'(bus.data), 32'h1000);
    bus.out_ready = 1'b1;
    #1;
    chk("resume_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, W'(16'h2000 + k), W'(16'h0003), 2'd2);
      step();
      chk("resume_out_valid", 32'(bus.out_valid), 32'd1);
    end
    drain("stall_drain");

    // Bubble collapse under stall
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive((k % 2) == 0, W'(16'h0300 + k), W'(16'h0030), 2'd1);
      step();
    end
    #1;
    chk("bubble_occupancy", 32'(bus.occupancy), 32'(S));
    chk("bubble_in_ready", 32'(bus.in_ready), 32'd0);
    drain("bubble_drain");

    // Flush with two entries in flight and a pair offered
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, W'(16'h0700 + k), W'(16'h0007), 2'd0);
      step();
    end
    drive(1'b1, 16'h4444, 16'h1111, 2'd0);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, 2'd0);
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready_after", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0F00, 16'h00F0, 2'd0);
    step();
    drive(1'b0, '0, '0, 2'd0);
    step();
    chk("post_flush_early", 32'(bus.out_valid), 32'd0);
    step();
    chk("post_flush_valid", 32'(bus.out_valid), 32'd1);
    chk("post_flush_data", 32'(bus.data), 32'h0FF0);
    drain("post_flush_drain");

    // Asynchronous reset while a result is presented
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, W'(16'h1357 + k), 16'h0246, 2'd0);
      step();
    end
    drive(1'b0, '0, '0, 2'd0);
    chk("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data", 32'(bus.data), 32'd0);
    chk("arst_lo", 32'(bus.lo), 32'd0);
    chk("arst_tag", 32'(bus.tag), 32'd0);
    chk("arst_carry", 32'(bus.carry), 32'd0);
    chk("arst_occupancy", 32'(bus.occupancy), 32'd0);
    q.delete();
    @(negedge sys_clk);
    #1;
    sys_rst = 1'b0;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
